vreg_writeback: RTL
===================

# vreg_writeback

Write-side front end for the vector register file: accepts results from the ALU and from the memory/load path through valid/ready handshakes, buffers them in a small in-order queue, and drives the register file's write ports (WE3/A3/WD3/WSFlag/LDSFlag and WE1/SP1/WD1) with registered, conflict-free writes. It also reports pending writes for hazard detection in decode.

## Interface
- DEPTH, 4, queue entries (power of two, ≥2)
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted when alu_valid && alu_ready at posedge
- alu_rd  in  4  destination register index 0..15
- alu_data  in  [5:0][7:0]  vector result
- mem_valid  in  1  load result offered
- mem_ready  out  1  handshake as for ALU
- mem_rd  in  4  vector: register 0..15; scalar: lane 0..5
- mem_data  in  [5:0][7:0]  load data; scalar uses byte [0] only
- mem_scalar  in  1  1 = scalar lane load into register 0
- sp_valid / sp_ready  in / out  1  stack-pointer update handshake
- sp_idx  in  4  address register index 11..15
- sp_data  in  [5:0][7:0]  new stack-pointer value
- WE3, A3, WD3, WSFlag, LDSFlag  out  1, 4, [5:0][7:0], 1, 1  main regfile write port (registered)
- WE1, SP1, WD1  out  1, 4, [5:0][7:0]  stack-pointer write port (registered)
- chk_idx  in  4  register queried by decode
- chk_pending  out  1  combinational: a write to chk_idx is queued or on WE3
- err  out  1  sticky: illegal request dropped

## Operation
- Queue entry = {rd, data, scalar}; FIFO order, count 0..DEPTH.
- Arbitration: at most one push per cycle. Both valid → round-robin via 1-bit last_grant (reset: ALU preferred). Only one valid → it is granted. alu_ready = !full && grant==ALU; mem_ready likewise; ready never depends on a same-cycle pop.
- Pop: every cycle the queue is non-empty, head loads the WE3 output stage: WE3=1, A3=rd, WD3=data, WSFlag=LDSFlag=scalar. Empty → WE3=0 (A3/WD3 hold).
- Scalar load with mem_rd>5: accepted (ready handshake completes), not queued, err←1.
- SP path: one-entry holding register. sp_ready = holding empty. Holding register issues WE1/SP1/WD1 next cycle unless the WE3 stage is about to load an entry with rd==held sp_idx (vector), in which case SP waits one cycle (register file lets WE3 win; this avoids lost SP updates). sp_idx outside 11..15: accepted, dropped, err←1.
- chk_pending = OR over valid queue entries and WE3 stage: vector match rd==chk_idx; scalar entries match chk_idx==0.
- err cleared only by rst.

## Timing
- Reset values: queue empty, count=0, WE3=0, A3=0, WD3=0, WSFlag=LDSFlag=0, WE1=0, SP1=0, WD1=0, err=0, last_grant=MEM (so ALU wins first tie), SP holding empty.
- Latency: accept at edge k → head at edge k → WE3 high during cycle after edge k+1 → regfile written at edge k+2. Back-to-back accepts give WE3 high every cycle (throughput 1/cycle).
- Full (count==DEPTH): both readies 0 even if a pop occurs that cycle; readies reassert the cycle after count drops.
- Push and pop same edge with 0<count<DEPTH: count unchanged; order preserved.
- Pointers wrap modulo DEPTH.
- SP: accept at edge k → WE1 high one cycle after edge k+1 (deferred by one cycle per conflict); WE1 is a single-cycle pulse.
- rst mid-operation: all queued/held writes discarded, outputs to reset values asynchronously; handshakes in the reset cycle are lost.

## Test plan
- Single ALU write rd=5 data 01..06 → WE3 pulse one cycle, A3=5, WD3=06 05 04 03 02 01, WSFlag=LDSFlag=0, two edges after accept.
- Both sources valid every cycle, 8 requests each → accepts alternate ALU, MEM, ALU…; WE3 order matches accept order; queue never exceeds DEPTH; readies drop at count 4.
- Scalar load mem_rd=3, byte 0x7F → WE3 with A3=3, WSFlag=LDSFlag=1, WD3[0]=7F; mem_rd=9 scalar → no WE3, err=1.
- SP write idx 12 while ALU write rd=12 reaches WE3 stage → WE3 cycle first, WE1 one cycle later; final reg 12 = SP data.
- chk_idx=7 with ALU rd=7 queued → chk_pending=1 from accept edge until WE3 deasserts; chk_idx=0 with queued scalar → 1.
- Assert rst with 3 queued entries → WE3=0 immediately, no further writes, err=0, readies 1 after release.

Source files
------------

// File: rtl/vreg_writeback_if.sv
// vreg_writeback_if: producer handshakes, register-file write ports and hazard query of the writeback stage
interface vreg_writeback_if;
  logic alu_valid;
  logic alu_ready;
  logic [3:0] alu_rd;
  logic [5:0][7:0] alu_data;
  logic mem_valid;
  logic mem_ready;
  logic [3:0] mem_rd;
  logic [5:0][7:0] mem_data;
  logic mem_scalar;
  logic sp_valid;
  logic sp_ready;
  logic [3:0] sp_idx;
  logic [5:0][7:0] sp_data;
  logic WE3;
  logic [3:0] A3;
  logic [5:0][7:0] WD3;
  logic WSFlag;
  logic LDSFlag;
  logic WE1;
  logic [3:0] SP1;
  logic [5:0][7:0] WD1;
  logic [3:0] chk_idx;
  logic chk_pending;
  logic err;
  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, mem_scalar,
           sp_valid, sp_idx, sp_data, chk_idx,
    input  alu_ready, mem_ready, sp_ready, WE3, A3, WD3, WSFlag, LDSFlag,
           WE1, SP1, WD1, chk_pending, err
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, mem_scalar,
           sp_valid, sp_idx, sp_data, chk_idx,
    output alu_ready, mem_ready, sp_ready, WE3, A3, WD3, WSFlag, LDSFlag,
           WE1, SP1, WD1, chk_pending, err
  );
endinterface

// File: rtl/vreg_writeback.sv
// vreg_writeback: arbitrated in-order write queue feeding registered regfile write ports with hazard reporting
module vreg_writeback #(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  vreg_writeback_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic {GNT_ALU, GNT_MEM} gnt_e;
  gnt_e last_grant_q, last_grant_d;
  logic [3:0] rd_q [DEPTH];
  logic [3:0] rd_d [DEPTH];
  logic [5:0][7:0] data_q [DEPTH];
  logic [5:0][7:0] data_d [DEPTH];
  logic sc_q [DEPTH];
  logic sc_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0] count_q, count_d;
  logic we3_q, we3_d, ws_q, ws_d;
  logic [3:0] a3_q, a3_d;
  logic [5:0][7:0] wd3_q, wd3_d;
  logic sp_v_q, sp_v_d;
  logic [3:0] sp_idx_q, sp_idx_d;
  logic [5:0][7:0] sp_data_q, sp_data_d;
  logic we1_q, we1_d;
  logic [3:0] sp1_q, sp1_d;
  logic [5:0][7:0] wd1_q, wd1_d;
  logic err_q, err_d;
  logic full, alu_wins, mem_wins, alu_fire, mem_fire, mem_bad, push, pop;
  logic sp_fire, sp_bad, sp_block, pend;
  always_comb begin
    full = count_q == (PW+1)'(DEPTH);
    alu_wins = bus.alu_valid && (!bus.mem_valid || last_grant_q == GNT_MEM);
    mem_wins = bus.mem_valid && (!bus.alu_valid || last_grant_q == GNT_ALU);
    bus.alu_ready = !full && !mem_wins;
    bus.mem_ready = !full && !alu_wins;
    bus.sp_ready = !sp_v_q;
    alu_fire = bus.alu_valid && bus.alu_ready;
    mem_fire = bus.mem_valid && bus.mem_ready;
    mem_bad = bus.mem_scalar && bus.mem_rd > 4'd5;
    push = alu_fire || (mem_fire && !mem_bad);
    pop = count_q != '0;
    sp_fire = bus.sp_valid && !sp_v_q;
    sp_bad = bus.sp_idx < 4'd11;
    sp_block = pop && !sc_q[rd_ptr_q] && rd_q[rd_ptr_q] == sp_idx_q;
    rd_d = rd_q;
    data_d = data_q;
    sc_d = sc_q;
    if (push) begin
      rd_d[wr_ptr_q] = alu_fire ? bus.alu_rd : bus.mem_rd;
      data_d[wr_ptr_q] = alu_fire ? bus.alu_data : bus.mem_data;
      sc_d[wr_ptr_q] = !alu_fire && bus.mem_scalar;
    end
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    last_grant_d = alu_fire ? GNT_ALU : mem_fire ? GNT_MEM : last_grant_q;
    we3_d = pop;
    a3_d = pop ? rd_q[rd_ptr_q] : a3_q;
    wd3_d = pop ? data_q[rd_ptr_q] : wd3_q;
    ws_d = pop ? sc_q[rd_ptr_q] : ws_q;
    we1_d = sp_v_q && !sp_block;
    sp1_d = we1_d ? sp_idx_q : sp1_q;
    wd1_d = we1_d ? sp_data_q : wd1_q;
    sp_v_d = sp_v_q ? sp_block : sp_fire && !sp_bad;
    sp_idx_d = sp_fire ? bus.sp_idx : sp_idx_q;
    sp_data_d = sp_fire ? bus.sp_data : sp_data_q;
    err_d = err_q || (mem_fire && mem_bad) || (sp_fire && sp_bad);
    pend = we3_q && (ws_q ? bus.chk_idx == 4'd0 : a3_q == bus.chk_idx);
    for (int i = 0; i < DEPTH; i++)
      if ({1'b0, PW'(PW'(i) - rd_ptr_q)} < count_q &&
          (sc_q[i] ? bus.chk_idx == 4'd0 : rd_q[i] == bus.chk_idx))
        pend = 1'b1;
    bus.chk_pending = pend;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i] <= '0;
        data_q[i] <= '0;
        sc_q[i] <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      last_grant_q <= GNT_MEM;
      we3_q <= 1'b0;
      a3_q <= '0;
      wd3_q <= '0;
      ws_q <= 1'b0;
      sp_v_q <= 1'b0;
      sp_idx_q <= '0;
      sp_data_q <= '0;
      we1_q <= 1'b0;
      sp1_q <= '0;
      wd1_q <= '0;
      err_q <= 1'b0;
    end else begin
      rd_q <= rd_d;
      data_q <= data_d;
      sc_q <= sc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      last_grant_q <= last_grant_d;
      we3_q <= we3_d;
      a3_q <= a3_d;
      wd3_q <= wd3_d;
      ws_q <= ws_d;
      sp_v_q <= sp_v_d;
      sp_idx_q <= sp_idx_d;
      sp_data_q <= sp_data_d;
      we1_q <= we1_d;
      sp1_q <= sp1_d;
      wd1_q <= wd1_d;
      err_q <= err_d;
    end
  assign bus.WE3 = we3_q;
  assign bus.A3 = a3_q;
  assign bus.WD3 = wd3_q;
  assign bus.WSFlag = ws_q;
  assign bus.LDSFlag = ws_q;
  assign bus.WE1 = we1_q;
  assign bus.SP1 = sp1_q;
  assign bus.WD1 = wd1_q;
  assign bus.err = err_q;
endmodule
